// File: rtl/ahb_master_burst_req.sv
// ahb_master_burst_req: AHB master burst engine; requests the bus, then issues pipelined address/data phases for one client burst
module ahb_master_burst_req #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_burst,
  output logic                  hreq,
  input  logic                  hgrant,
  input  logic                  hwait,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hburst,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  done
);
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_ADDR = 2'd2, S_LAST = 2'd3;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
  logic [1:0] state;
  logic [3:0] cnt, last, cmd_last;
  logic dphase, aphase, wrap;
  logic [ADDR_WIDTH-1:0] mask, next_addr;
  always_comb begin
    cmd_last = cmd_burst[2:1] == 2'd0 ? 4'd0 : cmd_burst[2:1] == 2'd1 ? 4'd3 : cmd_burst[2:1] == 2'd2 ? 4'd7 : 4'd15;
    aphase = state == S_ADDR && htrans[1];
    wrap = hburst != 3'd0 && !hburst[0];
    mask = ADDR_WIDTH'({last, 2'b11});
    next_addr = wrap ? (haddr & ~mask) | ((haddr + ADDR_WIDTH'(4)) & mask) : haddr + ADDR_WIDTH'(4);
    cmd_ready = state == S_IDLE;
    wdata_ack = dphase & hwrite & ~hwait;
    hwdata = dphase & hwrite ? wdata : '0;
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= S_IDLE;
      cnt <= '0;
      last <= '0;
      dphase <= 1'b0;
      hreq <= 1'b0;
      haddr <= '0;
      htrans <= T_IDLE;
      hwrite <= 1'b0;
      hburst <= '0;
      rdata <= '0;
      rdata_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      done <= 1'b0;
      if (dphase && !hwait && !hwrite) begin
        rdata <= hrdata;
        rdata_valid <= 1'b1;
      end
      case (state)
        S_IDLE: if (cmd_valid) begin
          state <= S_REQ;
          hreq <= 1'b1;
          haddr <= cmd_addr;
          hwrite <= cmd_write;
          hburst <= cmd_burst == 3'd1 ? 3'd0 : cmd_burst;
          last <= cmd_last;
          cnt <= '0;
        end
        S_REQ: if (hgrant) begin
          state <= S_ADDR;
          htrans <= T_NONSEQ;
        end
        // BUSY already shows the next beat's address, so resuming SEQ just repeats it
        S_ADDR: if (!hwait) begin
          dphase <= aphase;
          if (aphase) begin
            cnt <= cnt + 4'd1;
            if (cnt == last) begin
              state <= S_LAST;
              hreq <= 1'b0;
              htrans <= T_IDLE;
            end else begin
              haddr <= next_addr;
              htrans <= hgrant ? T_SEQ : T_BUSY;
            end
          end else if (hgrant) htrans <= T_SEQ;
        end
        S_LAST: if (!hwait) begin
          dphase <= 1'b0;
          done <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/ahb_master_burst_req.md
# ahb_master_burst_req

Master-side bus request engine for the AHB fabric: the initiator counterpart of the per-slave arbiter. It accepts one burst command at a time from a local client and raises `hreq` toward the arbiter. Once `hgrant` is received it drives pipelined address and data phases for the whole burst, honours `hwait` stalls, and releases `hreq` when the last address phase is accepted. Write data is pulled from the client and read data is pushed back to it beat by beat.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width. Transfer size is fixed at word (4-byte address step).

- `hclk`  in  1  clock; all logic on rising edge.
- `hreset`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  burst command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_addr`  in  ADDR_WIDTH  start address, word aligned.
- `cmd_write`  in  1  1 = write burst, 0 = read burst.
- `cmd_burst`  in  3  hburst_type encoding: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- `hreq`  out  1  bus request to the arbiter.
- `hgrant`  in  1  grant from the arbiter; already masked with `~hwait`.
- `hwait`  in  1  slave stall; 1 holds the current address and data phase.
- `haddr`  out  ADDR_WIDTH  address-phase address.
- `htrans`  out  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `hwrite`  out  1  direction, valid with `htrans`≠IDLE.
- `hburst`  out  3  burst type of the current transaction.
- `hwdata`  out  DATA_WIDTH  write data; equals `wdata` during a write data phase.
- `hrdata`  in  DATA_WIDTH  read data.
- `wdata`  in  DATA_WIDTH  client write word for the current data-phase beat.
- `wdata_ack`  out  1  current write beat consumed; client advances to the next word.
- `rdata`  out  DATA_WIDTH  captured read word.
- `rdata_valid`  out  1  `rdata` valid; 1-cycle pulse.
- `done`  out  1  1-cycle pulse on completion of the final data phase.

## Operation
- States: IDLE, REQ, ADDR, LAST.
- **IDLE:** `cmd_ready`=1. On accept, latch addr, write, burst and beat count.
  - Beat count: SINGLE/INCR=1, x4=4, x8=8, x16=16.
  - INCR is issued as SINGLE; `hburst` is driven 0.
  - Next state: REQ.
- **REQ:** `hreq`=1, `htrans`=IDLE. When `hgrant`=1 is sampled at an edge, go to ADDR and drive NONSEQ at the latched address.
- **ADDR:** `hreq`=1. An edge with `hwait`=0 completes the current address phase.
  - Each completion sets the data-phase flag for that beat and increments the 4-bit beat counter.
  - If beats remain: next `htrans`=SEQ and next address = address + 4.
  - Wrap bursts stay within their block. Mask M = beats*4-1; next = (addr & ~M) | ((addr+4) & M).
  - If `hgrant`=0 and `hwait`=0 before the final address phase, drive BUSY and hold address and counter. Resume SEQ when `hgrant` returns.
  - When the last address phase completes, go to LAST.
- **LAST:** `hreq`=0, `htrans`=IDLE. Final data phase in progress. An edge with `hwait`=0 pulses `done` and returns to IDLE.
- **Data phase rules** (when the data-phase flag is set and `hwait`=0):
  - Write: `wdata_ack`=1, combinational.
  - Read: at that edge `rdata` <= `hrdata` and `rdata_valid` pulses the next cycle.
- **Stalls:** `hwait`=1 freezes state, counter, `haddr`, `htrans`, `hwdata` and the data-phase flag.

## Timing
- **Reset values:** state IDLE; `cmd_ready`=1 after reset deasserts; `hreq`=0; `htrans`=IDLE; `haddr`=0; `hwrite`=0; `hburst`=0; `rdata`=0; `rdata_valid`=0; `wdata_ack`=0; `done`=0.
- **Reset mid-burst:** abandon the burst and return to IDLE at that edge. No `done` pulse.
- `haddr`, `htrans`, `hwrite`, `hburst`, `hreq`, `rdata` and `rdata_valid` are registered. `cmd_ready`, `wdata_ack` and `hwdata` are combinational from state and flag.
- Command accepted at edge 0 → `hreq`=1 in cycle 1.
  - Arbiter registers the grant, so `hgrant`=1 appears in cycle 2 at the earliest.
  - First NONSEQ is driven in cycle 3.
- An N-beat burst with no stalls occupies N address cycles plus 1 LAST cycle. `done` is asserted in the cycle after the last data phase completes.
- Data phase of beat k overlaps the address phase of beat k+1.
- A new command is not accepted until the cycle after `done`, so back-to-back bursts always re-request.

## Test plan
- **SINGLE read:** addr 0x100, `hgrant` in cycle 2, no stalls → NONSEQ 0x100 in cycle 3, `hreq` low in cycle 4, `rdata_valid` and `done` in cycle 5.
- **INCR4 write:** addr 0x200 → addresses 0x200/0x204/0x208/0x20C with NONSEQ,SEQ,SEQ,SEQ; exactly 4 `wdata_ack` pulses; `hwdata` matches the client words in order.
- **WRAP8 read:** addr 0x3F8 → 0x3F8, 0x3FC, 0x3E0, 0x3E4, 0x3E8, 0x3EC, 0x3F0, 0x3F4; 8 `rdata_valid` pulses.
- **Stalls:** INCR4 with `hwait`=1 for 2 cycles on beat 2 → all address-phase outputs and the beat counter hold; burst completes 2 cycles later with no duplicate or skipped beats.
- **Grant drop:** `hgrant` low for 1 cycle mid-INCR8 → one BUSY cycle with address held, then SEQ resumes; total of 8 beats.
- **Reset:** `hreset` asserted mid-WRAP16 → next cycle `htrans`=IDLE, `hreq`=0, `cmd_ready`=1, no `done`; a following SINGLE command completes normally.
